add_req_arbiter: RTL

//  Shares one pipelined W-bit adder datapath among N requesters. Each cycle it grants one requester,

---
 rtl/add_arb_pkg.sv | 22 ++
 rtl/add_req_arbiter_rr_grant.sv | 49 ++++
 rtl/add_req_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/add_arb_pkg.sv
// Shared types for the adder request arbiter: FSM states, tag-pipe entry, ID width helper.
package add_arb_pkg;

    // Widest requester ID the tag pipe must carry (N up to 8).
    localparam int MAX_ID_W = 3;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HELD  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } add_tag_t;

endpackage

// File: rtl/add_req_arbiter_rr_grant.sv
// One-hot grant selector: round-robin from i_ptr, or lowest-index-wins when
// ADDARB_FIXED_PRIO_EN is defined.
module rr_grant #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic            i_en,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_gnt_idx
);

`ifdef ADDARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_en && i_req[i]) begin
                o_gnt     = '0;
                o_gnt[i]  = 1'b1;
                o_gnt_idx = ID_W'(i);
            end
        end
    end
`else
    always_comb begin
        logic w_found;
        int   w_idx;
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        // Walk N slots starting at the pointer; first requester found wins.
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_en && !w_found && i_req[w_idx]) begin
                w_found       = 1'b1;
                o_gnt[w_idx]  = 1'b1;
                o_gnt_idx     = ID_W'(w_idx);
            end
        end
    end
`endif

endmodule

// File: rtl/add_req_arbiter.sv
// Shares one pipelined adder among N requesters with a tag pipe returning sums to owners
// and a RUN/DRAIN/HELD quiesce FSM. Build option: ADDARB_FIXED_PRIO_EN (fixed priority).
module add_req_arbiter
    import add_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 20,
    parameter int ADD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic           add_start,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_y,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    input  logic           hold,
    output logic           held,
    output logic           busy
);

    localparam int ID_W = id_w(N);

    arb_state_e      r_state, w_state_nxt;
    logic [N-1:0]    w_gnt;
    logic [ID_W-1:0] w_gnt_idx;
    logic [ID_W-1:0] w_ptr;
    logic            w_run;
    logic            w_xfer;
    logic            w_busy;
    logic [W-1:0]    w_sel_a, w_sel_b;
    add_tag_t        r_tag [ADD_LAT];
    logic            r_add_start;
    logic [W-1:0]    r_add_a, r_add_b;
    logic [N-1:0]    r_rsp_valid;
    logic [W-1:0]    r_rsp_data;

    // hold takes effect in the same cycle it rises, so it also blocks the grant.
    assign w_run = (r_state == RUN) && !hold;

    rr_grant #(.N(N), .ID_W(ID_W)) u_grant (
        .i_req     (req_valid),
        .i_en      (w_run),
        .i_ptr     (w_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    assign w_xfer    = |(req_valid & w_gnt);
    assign w_sel_a   = req_a[w_gnt_idx*W +: W];
    assign w_sel_b   = req_b[w_gnt_idx*W +: W];

`ifdef ADDARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [ID_W-1:0] r_ptr;
    assign w_ptr = r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_idx == ID_W'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_start <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
        end else begin
            r_add_start <= w_xfer;
            if (w_xfer) begin
                r_add_a <= w_sel_a;
                r_add_b <= w_sel_b;
            end
        end
    end

    // Stage 0 lines up with add_start; the last stage lines up with the sum on add_y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ADD_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0].vld <= w_xfer;
            r_tag[0].id  <= MAX_ID_W'(w_gnt_idx);
            for (int k = 1; k < ADD_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else if (r_tag[ADD_LAT-1].vld) begin
            r_rsp_valid <= N'(1) << r_tag[ADD_LAT-1].id;
            r_rsp_data  <= add_y;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k < ADD_LAT; k++) begin
            w_busy = w_busy | r_tag[k].vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (hold) w_state_nxt = DRAIN;
            DRAIN:   begin
                if (!hold) begin
                    w_state_nxt = RUN;
                end else if (!w_busy) begin
                    w_state_nxt = HELD;
                end
            end
            HELD:    if (!hold) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    assign add_start = r_add_start;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign held      = (r_state == HELD);
    assign busy      = w_busy;

endmodule
